// File: rtl/nand_arb_pkg.sv
// Shared types for the NAND-unit arbiter: FSM states and operation modes.
package nand_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic MODE_NAND = 1'b0;
    localparam logic MODE_NOT  = 1'b1;

endpackage

// File: rtl/nand_unit_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
module nand_unit_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [IDW-1:0]   winner,
    output logic             any
);

    // Scan from the farthest offset back so the nearest hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                winner = IDW'((int'(rr_ptr) + k) % N_REQ);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nand_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit NAND unit among N_REQ requesters.
import nand_arb_pkg::*;

module nand_unit_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    input  logic [N_REQ-1:0]   mode,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       result,
    output logic [IDW-1:0]     result_id,
    output logic               result_valid,
    output logic               busy
);

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             mode_q, mode_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]     result_q, result_d;
    logic [IDW-1:0]   result_id_q, result_id_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;

    logic [IDW-1:0]   winner;
    logic             any;

    nand_unit_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .any    (any)
    );

    // NOT mode feeds A to both gate inputs.
    logic [W-1:0] nand_b;
    logic [W-1:0] nand_y;

    assign nand_b = (mode_q == MODE_NOT) ? a_q : b_q;

    for (genvar g = 0; g < W; g++) begin : g_nand
        nand u_nand (nand_y[g], a_q[g], nand_b[g]);
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        a_d            = a_q;
        b_d            = b_q;
        mode_d         = mode_q;
        gnt_d          = '0;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    a_d     = op_a[int'(winner)*W +: W];
                    b_d     = op_b[int'(winner)*W +: W];
                    mode_d  = mode[winner];
                    id_d    = winner;
                    gnt_d   = N_REQ'(1) << winner;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d       = nand_y;
                result_id_d    = id_q;
                result_valid_d = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                rr_ptr_d = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            mode_q         <= MODE_NAND;
            gnt_q          <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            a_q            <= a_d;
            b_q            <= b_d;
            mode_q         <= mode_d;
            gnt_q          <= gnt_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign gnt          = gnt_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Self-checking bench: per-cycle model comparison plus directed literal checks.
module tb_nand_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]  mode;
    logic [N-1:0]  gnt;
    logic [W-1:0]  result;
    logic [1:0]    result_id;
    logic          result_valid;
    logic          busy;

    nand_unit_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .mode         (mode),
        .gnt          (gnt),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op occupies the unit for 3 cycles.
    int         m_left;
    int         m_ptr;
    int         p_id;
    logic [7:0] p_val;
    logic [3:0] m_gnt;
    logic [7:0] m_res;
    int         m_id;
    logic       m_val;
    logic       m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_ptr = 0; p_id = 0; p_val = 0;
            m_gnt = 0; m_res = 0; m_id = 0; m_val = 0; m_busy = 0;
        end else if (m_left == 0) begin
            m_val = 0; m_busy = 0; m_gnt = 0;
            if (req != 0) begin
                bit found;
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        p_id  = (m_ptr + k) % N;
                        found = 1;
                    end
                end
                if (mode[p_id])
                    p_val = ~op_a[p_id*W +: W];
                else
                    p_val = ~(op_a[p_id*W +: W] & op_b[p_id*W +: W]);
                m_gnt  = 4'(1 << p_id);
                m_busy = 1;
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_gnt = 0; m_res = p_val; m_id = p_id; m_val = 1; m_left = 1;
        end else begin
            m_val = 0; m_busy = 0; m_ptr = (p_id + 1) % N; m_left = 0;
        end
    end

    bit saw_g1, saw_r1, saw_val;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_valid", 32'(result_valid), 32'(m_val));
            chk("model_result", 32'(result), 32'(m_res));
            if (m_val) chk("model_id", 32'(result_id), 32'(m_id));
            if (gnt[1]) saw_g1 = 1;
            if (result_valid && result_id == 2'd1) saw_r1 = 1;
            if (result_valid) saw_val = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_result"}, 32'(result), 0);
        chk({nm, "_id"}, 32'(result_id), 0);
        chk({nm, "_valid"}, 32'(result_valid), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    int got[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int last_v;

    initial begin
        rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; mode = '0;
        #1;
        chk_zero("reset_async");
        #11 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_busy", 32'(busy), 0);
        end

        // Single NAND on requester 2
        op_a[23:16] = 8'hF0; op_b[23:16] = 8'h3C; req = 4'b0100;
        step();
        chk("nand_gnt", 32'(gnt), 32'h4);
        chk("nand_busy", 32'(busy), 1);
        req = '0;
        step();
        chk("nand_valid", 32'(result_valid), 1);
        chk("nand_result", 32'(result), 32'hCF);
        chk("nand_id", 32'(result_id), 2);
        step(); step();

        // NOT mode on requester 0, B ignored
        op_a[7:0] = 8'hA5; op_b[7:0] = 8'hFF; mode = 4'b0001; req = 4'b0001;
        step();
        chk("not_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        chk("not_valid", 32'(result_valid), 1);
        chk("not_result", 32'(result), 32'h5A);
        chk("not_id", 32'(result_id), 0);
        mode = '0;
        step(); step();

        // Contention from a fresh rr_ptr
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        op_a = 32'h1248_8421; op_b = 32'hF00F_0FF0;
        req = 4'hF; last_v = -1;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            step();
            if (result_valid) begin
                if (last_v >= 0) chk("valid_spacing", 32'(c - last_v), 3);
                last_v = c;
            end
            if (gnt != 0) begin
                got.push_back($clog2(gnt));
                req = 4'hF & ~gnt;
            end else begin
                req = 4'hF;
            end
        end
        req = '0;
        for (int i = 0; i < 5; i++)
            chk("grant_order", (i < got.size()) ? 32'(got[i]) : 32'd99,
                32'(exp_order[i]));
        step(); step(); step();

        // Request withdrawn while the unit is executing
        op_a[31:24] = 8'h0F; op_b[31:24] = 8'hFF; req = 4'b1000;
        step();
        saw_g1 = 0; saw_r1 = 0;
        req = 4'b0010;
        step();
        req = '0;
        repeat (6) step();
        chk("withdrawn_gnt1", 32'(saw_g1), 0);
        chk("withdrawn_res1", 32'(saw_r1), 0);

        // Reset during EXEC
        op_a[23:16] = 8'h33; op_b[23:16] = 8'h55; req = 4'b0100;
        step();
        chk("midop_gnt", 32'(gnt), 32'h4);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("reset_midop");
        saw_val = 0;
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("midop_novalid", 32'(saw_val), 0);
        op_a[31:24] = 8'h81; op_b[31:24] = 8'h18; req = 4'b1000;
        step();
        chk("post_gnt", 32'(gnt), 32'h8);
        req = '0;
        step();
        chk("post_valid", 32'(result_valid), 1);
        chk("post_result", 32'(result), 32'hFF);
        chk("post_id", 32'(result_id), 3);
        step(); step();
        req = 4'b1010;
        step();
        chk("wrap_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
